// File: rtl/xor_tree_feeder_5_31.sv
// -----------------------------------------------------------------------------
// xor_tree_feeder_5_31
//
// Serial-to-parallel front end for the GF(2^31) PRNG XOR reduction stage.
// NUM_VECTORS words arrive one at a time on a valid/ready port. Each word is
// written into its own slice of the packed bus that drives an external
// combinational XOR tree. Once the bus is full, the tree output is captured and
// offered on a valid/ready result port.
//
// A running XOR of the same words is kept locally as a cross-check on the tree.
// Any disagreement at capture time sets a sticky error flag. Only reset clears
// that flag.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   s_valid       in   input word valid
//   s_ready       out  feeder can accept a word (high only while collecting)
//   s_data        in   input word, WIDTH bits
//   tree_vectors  out  packed bus to tree in_vectors; word k sits in slice k
//   tree_xor      in   tree out_xor, combinational from tree_vectors
//   m_valid       out  result valid
//   m_ready       in   result consumer ready
//   m_data        out  reduction result, WIDTH bits
//   busy          out  high while evaluating or holding a result
//   err           out  sticky tree/internal-XOR disagreement flag
// -----------------------------------------------------------------------------
module xor_tree_feeder_5_31 #(
  parameter int NUM_VECTORS = 5,
  parameter int WIDTH       = 31,
  parameter int CNT_W       = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH-1:0]             s_data,
  output logic [NUM_VECTORS*WIDTH-1:0] tree_vectors,
  input  logic [WIDTH-1:0]             tree_xor,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic                         busy,
  output logic                         err
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EVAL    = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [WIDTH-1:0] acc;

  logic s_fire;
  logic m_fire;

  // Addition in GF(2) is a carry-free bitwise XOR, so no result bits are lost.
  function automatic logic [WIDTH-1:0] gf2_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return a ^ b;
  endfunction

  // The tree and the local accumulator must agree bit for bit.
  function automatic logic xor_mismatch(input logic [WIDTH-1:0] tree_val,
                                        input logic [WIDTH-1:0] local_val);
    return |(tree_val ^ local_val);
  endfunction

  // Both decodes depend only on the registered state. This keeps s_ready
  // independent of s_valid and avoids a combinational path to the upstream port.
  assign s_ready = (state == ST_COLLECT);
  assign busy    = (state != ST_COLLECT);

  assign s_fire  = s_valid & s_ready;
  assign m_fire  = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_COLLECT;
      word_cnt     <= '0;
      acc          <= '0;
      tree_vectors <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      err          <= 1'b0;
    end else begin
      unique case (state)
        // collect: word k lands in slice k; the accumulator tracks the XOR
        ST_COLLECT: begin
          if (s_fire) begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
              if (word_cnt == CNT_W'(i)) begin
                tree_vectors[i*WIDTH +: WIDTH] <= s_data;
              end
            end
            acc      <= gf2_add(acc, s_data);
            word_cnt <= word_cnt + CNT_W'(1);
            if (word_cnt == LAST_IDX) begin
              state <= ST_EVAL;
            end
          end
        end

        // eval: the bus has been stable for a full cycle, so capture the tree
        ST_EVAL: begin
          m_data  <= tree_xor;
          m_valid <= 1'b1;
          if (xor_mismatch(tree_xor, acc)) begin
            err <= 1'b1;
          end
          state <= ST_OUTPUT;
        end

        // output: hold the result until it is taken. Old slices remain on the
        // bus and are overwritten one at a time by the next group.
        ST_OUTPUT: begin
          if (m_fire) begin
            m_valid  <= 1'b0;
            word_cnt <= '0;
            acc      <= '0;
            state    <= ST_COLLECT;
          end
        end

        default: begin
          state <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule
